// File: rtl/ex_mem_stage_if.sv
// E-to-M stage bundle: E-side instruction fields and pipeline controls in,
// fetch redirect, M-stage register contents and branch counters out.
interface ex_mem_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             ValidE;
   logic [XLEN-1:0]  ResultE;
   logic             ZeroE;
   logic             NegativeE;
   logic             CarryE;
   logic             OverFlowE;
   logic             RegWriteE;
   logic             MemWriteE;
   logic [1:0]       ResultSrcE;
   logic             BranchE;
   logic             JumpE;
   logic [2:0]       Funct3E;
   logic [4:0]       RdE;
   logic [XLEN-1:0]  WriteDataE;
   logic [XLEN-1:0]  PCPlus4E;
   logic [XLEN-1:0]  PCTargetE;
   logic             StallM;
   logic             FlushM;

   logic             PCSrcE;
   logic             ValidM;
   logic             RegWriteM;
   logic             MemWriteM;
   logic [1:0]       ResultSrcM;
   logic [4:0]       RdM;
   logic [XLEN-1:0]  ALUResultM;
   logic [XLEN-1:0]  WriteDataM;
   logic [XLEN-1:0]  PCPlus4M;
   logic [CNT_W-1:0] BrCountM;
   logic [CNT_W-1:0] BrTakenCountM;

   // master: the pipeline around the stage; slave: the stage itself.
   // The stage has no backpressure of its own: StallM holds, FlushM squashes.
   modport master (
      output ValidE, ResultE, ZeroE, NegativeE, CarryE, OverFlowE,
             RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, Funct3E,
             RdE, WriteDataE, PCPlus4E, PCTargetE, StallM, FlushM,
      input  PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM,
             ALUResultM, WriteDataM, PCPlus4M, BrCountM, BrTakenCountM
   );

   modport slave (
      input  ValidE, ResultE, ZeroE, NegativeE, CarryE, OverFlowE,
             RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, Funct3E,
             RdE, WriteDataE, PCPlus4E, PCTargetE, StallM, FlushM,
      output PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM,
             ALUResultM, WriteDataM, PCPlus4M, BrCountM, BrTakenCountM
   );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: resolves branches from ALU SUB flags, drives the
// fetch redirect, registers the M-stage fields and counts resolved/taken branches.
module ex_mem_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input logic           clk,
   input logic           rst,
   ex_mem_stage_if.slave bus
);

   logic             eq, slt, sltu, cond, taken, accept;

   logic             valid_q, valid_d;
   logic             regw_q, regw_d;
   logic             memw_q, memw_d;
   logic [1:0]       rsrc_q, rsrc_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  alu_q, alu_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [XLEN-1:0]  pc4_q, pc4_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

   // Flags come from A - B: carry set means no borrow, i.e. A >= B unsigned.
   assign eq   = bus.ZeroE;
   assign slt  = bus.NegativeE ^ bus.OverFlowE;
   assign sltu = ~bus.CarryE;

   always_comb begin
      cond = 1'b0;
      case (bus.Funct3E)
         3'b000:  cond = eq;
         3'b001:  cond = ~eq;
         3'b100:  cond = slt;
         3'b101:  cond = ~slt;
         3'b110:  cond = sltu;
         3'b111:  cond = ~sltu;
         default: cond = 1'b0;
      endcase
   end

   assign taken      = bus.JumpE | (bus.BranchE & cond);
   assign bus.PCSrcE = bus.ValidE & ~bus.FlushM & taken;
   assign accept     = bus.ValidE & ~bus.StallM & ~bus.FlushM;

   always_comb begin
      valid_d  = valid_q;
      regw_d   = regw_q;
      memw_d   = memw_q;
      rsrc_d   = rsrc_q;
      rd_d     = rd_q;
      alu_d    = alu_q;
      wdata_d  = wdata_q;
      pc4_d    = pc4_q;
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      // Flush beats stall; a bubble only clears the control bits, data fields hold.
      if (bus.FlushM) begin
         valid_d = 1'b0;
         regw_d  = 1'b0;
         memw_d  = 1'b0;
      end else if (!bus.StallM) begin
         valid_d = bus.ValidE;
         regw_d  = bus.RegWriteE & bus.ValidE;
         memw_d  = bus.MemWriteE & bus.ValidE;
         rsrc_d  = bus.ResultSrcE;
         rd_d    = bus.RdE;
         alu_d   = bus.ResultE;
         wdata_d = bus.WriteDataE;
         pc4_d   = bus.PCPlus4E;
      end
      if (accept && bus.BranchE) begin
         br_cnt_d = br_cnt_q + 1'b1;
         if (cond) tk_cnt_d = tk_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         regw_q   <= 1'b0;
         memw_q   <= 1'b0;
         rsrc_q   <= 2'b00;
         rd_q     <= 5'd0;
         alu_q    <= '0;
         wdata_q  <= '0;
         pc4_q    <= '0;
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
      end else begin
         valid_q  <= valid_d;
         regw_q   <= regw_d;
         memw_q   <= memw_d;
         rsrc_q   <= rsrc_d;
         rd_q     <= rd_d;
         alu_q    <= alu_d;
         wdata_q  <= wdata_d;
         pc4_q    <= pc4_d;
         br_cnt_q <= br_cnt_d;
         tk_cnt_q <= tk_cnt_d;
      end
   end

   assign bus.ValidM        = valid_q;
   assign bus.RegWriteM     = regw_q;
   assign bus.MemWriteM     = memw_q;
   assign bus.ResultSrcM    = rsrc_q;
   assign bus.RdM           = rd_q;
   assign bus.ALUResultM    = alu_q;
   assign bus.WriteDataM    = wdata_q;
   assign bus.PCPlus4M      = pc4_q;
   assign bus.BrCountM      = br_cnt_q;
   assign bus.BrTakenCountM = tk_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with 4-bit counters so wrap is reachable.
module tb_ex_mem_stage;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ex_mem_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_if ();

   ex_mem_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus_if.ValidE     = 1'b0;
      bus_if.ResultE    = '0;
      bus_if.ZeroE      = 1'b0;
      bus_if.NegativeE  = 1'b0;
      bus_if.CarryE     = 1'b0;
      bus_if.OverFlowE  = 1'b0;
      bus_if.RegWriteE  = 1'b0;
      bus_if.MemWriteE  = 1'b0;
      bus_if.ResultSrcE = 2'b00;
      bus_if.BranchE    = 1'b0;
      bus_if.JumpE      = 1'b0;
      bus_if.Funct3E    = 3'b000;
      bus_if.RdE        = 5'd0;
      bus_if.WriteDataE = '0;
      bus_if.PCPlus4E   = '0;
      bus_if.PCTargetE  = '0;
      bus_if.StallM     = 1'b0;
      bus_if.FlushM     = 1'b0;
   endtask

   task automatic set_branch(input logic [2:0] f3, input logic z, input logic n,
                             input logic c, input logic v);
      bus_if.ValidE    = 1'b1;
      bus_if.BranchE   = 1'b1;
      bus_if.JumpE     = 1'b0;
      bus_if.Funct3E   = f3;
      bus_if.ZeroE     = z;
      bus_if.NegativeE = n;
      bus_if.CarryE    = c;
      bus_if.OverFlowE = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      #1;
      checks++;
      if ({bus_if.ValidM, bus_if.RegWriteM, bus_if.MemWriteM, bus_if.ResultSrcM, bus_if.RdM} !== 10'd0 ||
          bus_if.ALUResultM !== 32'd0 || bus_if.BrCountM !== 4'd0 || bus_if.BrTakenCountM !== 4'd0) begin
         errors++;
         $display("FAIL reset_initial: ValidM=%b RdM=%0d ALUResultM=%h BrCount=%0d required all 0",
                  bus_if.ValidM, bus_if.RdM, bus_if.ALUResultM, bus_if.BrCountM);
      end
      bus_if.ValidE     = 1'b1;
      bus_if.ResultE    = 32'h0000_1234;
      bus_if.RegWriteE  = 1'b1;
      bus_if.MemWriteE  = 1'b1;
      bus_if.ResultSrcE = 2'b01;
      bus_if.RdE        = 5'd3;
      bus_if.WriteDataE = 32'hCAFE_0001;
      bus_if.PCPlus4E   = 32'h0000_0104;
      #2;
      rst = 1'b0;
      step();
      checks++;
      if (bus_if.ALUResultM !== 32'h1234 || bus_if.ValidM !== 1'b1 || bus_if.RdM !== 5'd3 ||
          bus_if.ResultSrcM !== 2'b01 || bus_if.WriteDataM !== 32'hCAFE_0001 ||
          bus_if.PCPlus4M !== 32'h104 || bus_if.RegWriteM !== 1'b1 || bus_if.MemWriteM !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_load: ALUResultM=%h ValidM=%b RdM=%0d WriteDataM=%h PCPlus4M=%h required 1234 1 3 cafe0001 104",
                  bus_if.ALUResultM, bus_if.ValidM, bus_if.RdM, bus_if.WriteDataM, bus_if.PCPlus4M);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus_if.ValidM, bus_if.RegWriteM, bus_if.MemWriteM, bus_if.ResultSrcM, bus_if.RdM} !== 10'd0 ||
          bus_if.ALUResultM !== 32'd0 || bus_if.WriteDataM !== 32'd0 || bus_if.PCPlus4M !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: ValidM=%b RdM=%0d ALUResultM=%h WriteDataM=%h required all 0",
                  bus_if.ValidM, bus_if.RdM, bus_if.ALUResultM, bus_if.WriteDataM);
      end
      step();
      checks++;
      if (bus_if.ALUResultM !== 32'd0 || bus_if.ValidM !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: ALUResultM=%h ValidM=%b required 0 0", bus_if.ALUResultM, bus_if.ValidM);
      end
      #1;
      rst = 1'b0;
      step();
      checks++;
      if (bus_if.ALUResultM !== 32'h1234 || bus_if.ValidM !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_load: ALUResultM=%h ValidM=%b required 1234 1", bus_if.ALUResultM, bus_if.ValidM);
      end
   endtask

   task automatic test_signed_unsigned();
      pulse_reset();
      // blt -1 < 1: SUB gives N=1 V=0 C=1
      set_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b1) begin
         errors++;
         $display("FAIL blt_signed: PCSrcE=%b required 1", bus_if.PCSrcE);
      end
      step();
      set_branch(3'b110, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL bltu_unsigned: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      // bge 0x80000000 vs 1: result 0x7fffffff, V=1 N=0 C=1
      set_branch(3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL bge_overflow: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      set_branch(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b1) begin
         errors++;
         $display("FAIL bgeu_taken: PCSrcE=%b required 1", bus_if.PCSrcE);
      end
      step();
      checks++;
      if (bus_if.BrCountM !== 4'd4 || bus_if.BrTakenCountM !== 4'd2) begin
         errors++;
         $display("FAIL signed_counts: BrCount=%0d Taken=%0d required 4 2", bus_if.BrCountM, bus_if.BrTakenCountM);
      end
      set_idle();
      bus_if.JumpE     = 1'b1;
      bus_if.RegWriteE = 1'b1;
      bus_if.MemWriteE = 1'b1;
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL invalid_no_redirect: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      checks++;
      if (bus_if.ValidM !== 1'b0 || bus_if.RegWriteM !== 1'b0 || bus_if.MemWriteM !== 1'b0) begin
         errors++;
         $display("FAIL invalid_gating: ValidM=%b RegWriteM=%b MemWriteM=%b required 0 0 0",
                  bus_if.ValidM, bus_if.RegWriteM, bus_if.MemWriteM);
      end
   endtask

   task automatic test_beq_bne();
      pulse_reset();
      set_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b1) begin
         errors++;
         $display("FAIL beq_taken: PCSrcE=%b required 1", bus_if.PCSrcE);
      end
      step();
      set_branch(3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL bne_not_taken: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      checks++;
      if (bus_if.BrCountM !== 4'd2 || bus_if.BrTakenCountM !== 4'd1) begin
         errors++;
         $display("FAIL beq_bne_counts: BrCount=%0d Taken=%0d required 2 1", bus_if.BrCountM, bus_if.BrTakenCountM);
      end
   endtask

   task automatic test_stall_hold();
      pulse_reset();
      bus_if.ValidE    = 1'b1;
      bus_if.RegWriteE = 1'b1;
      bus_if.RdE       = 5'd5;
      bus_if.ResultE   = 32'hA5A5_A5A5;
      step();
      bus_if.StallM  = 1'b1;
      bus_if.RdE     = 5'd9;
      bus_if.ResultE = 32'h0000_0000;
      set_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus_if.PCSrcE !== 1'b1) begin
            errors++;
            $display("FAIL stall_redirect[%0d]: PCSrcE=%b required 1", i, bus_if.PCSrcE);
         end
         step();
         checks++;
         if (bus_if.RdM !== 5'd5 || bus_if.ALUResultM !== 32'hA5A5_A5A5 || bus_if.BrCountM !== 4'd0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: RdM=%0d ALUResultM=%h BrCount=%0d required 5 a5a5a5a5 0",
                     i, bus_if.RdM, bus_if.ALUResultM, bus_if.BrCountM);
         end
      end
      bus_if.StallM = 1'b0;
      step();
      set_idle();
      checks++;
      if (bus_if.RdM !== 5'd9 || bus_if.ALUResultM !== 32'd0 || bus_if.BrCountM !== 4'd1 ||
          bus_if.BrTakenCountM !== 4'd1) begin
         errors++;
         $display("FAIL stall_release: RdM=%0d ALUResultM=%h BrCount=%0d Taken=%0d required 9 0 1 1",
                  bus_if.RdM, bus_if.ALUResultM, bus_if.BrCountM, bus_if.BrTakenCountM);
      end
      step();
      checks++;
      if (bus_if.BrCountM !== 4'd1 || bus_if.ValidM !== 1'b0) begin
         errors++;
         $display("FAIL stall_single_count: BrCount=%0d ValidM=%b required 1 0", bus_if.BrCountM, bus_if.ValidM);
      end
   endtask

   task automatic test_flush_vs_stall();
      pulse_reset();
      bus_if.ValidE    = 1'b1;
      bus_if.RegWriteE = 1'b1;
      bus_if.MemWriteE = 1'b1;
      bus_if.ResultE   = 32'h0000_0BEE;
      step();
      bus_if.FlushM     = 1'b1;
      bus_if.StallM     = 1'b1;
      bus_if.JumpE      = 1'b1;
      bus_if.ResultSrcE = 2'b10;
      bus_if.ResultE    = 32'h0000_0777;
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL flush_jal_redirect: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      checks++;
      if (bus_if.ValidM !== 1'b0 || bus_if.RegWriteM !== 1'b0 || bus_if.MemWriteM !== 1'b0 ||
          bus_if.ALUResultM !== 32'h0BEE) begin
         errors++;
         $display("FAIL flush_bubble: ValidM=%b RegWriteM=%b MemWriteM=%b ALUResultM=%h required 0 0 0 bee",
                  bus_if.ValidM, bus_if.RegWriteM, bus_if.MemWriteM, bus_if.ALUResultM);
      end
      bus_if.StallM = 1'b0;
      set_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus_if.BrCountM !== 4'd0 || bus_if.BrTakenCountM !== 4'd0 || bus_if.ValidM !== 1'b0) begin
         errors++;
         $display("FAIL flush_counters: BrCount=%0d Taken=%0d ValidM=%b required 0 0 0",
                  bus_if.BrCountM, bus_if.BrTakenCountM, bus_if.ValidM);
      end
      set_idle();
      bus_if.ValidE = 1'b1;
      bus_if.JumpE  = 1'b1;
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b1) begin
         errors++;
         $display("FAIL jal_redirect: PCSrcE=%b required 1", bus_if.PCSrcE);
      end
      step();
      checks++;
      if (bus_if.BrCountM !== 4'd0 || bus_if.ValidM !== 1'b1) begin
         errors++;
         $display("FAIL jal_not_counted: BrCount=%0d ValidM=%b required 0 1", bus_if.BrCountM, bus_if.ValidM);
      end
   endtask

   task automatic test_counter_wrap();
      pulse_reset();
      set_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) step();
      checks++;
      if (bus_if.BrCountM !== 4'd1 || bus_if.BrTakenCountM !== 4'd1) begin
         errors++;
         $display("FAIL counter_wrap: BrCount=%0d Taken=%0d required 1 1", bus_if.BrCountM, bus_if.BrTakenCountM);
      end
      set_branch(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus_if.PCSrcE !== 1'b0) begin
         errors++;
         $display("FAIL funct3_010_redirect: PCSrcE=%b required 0", bus_if.PCSrcE);
      end
      step();
      set_branch(3'b011, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      set_idle();
      checks++;
      if (bus_if.BrCountM !== 4'd3 || bus_if.BrTakenCountM !== 4'd1) begin
         errors++;
         $display("FAIL funct3_reserved_counts: BrCount=%0d Taken=%0d required 3 1",
                  bus_if.BrCountM, bus_if.BrTakenCountM);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_signed_unsigned();
      test_beq_bne();
      test_stall_hold();
      test_flush_vs_stall();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
